// File: rtl/dac_adc_sweep_ctrl_if.sv
// Stream/handshake bundle between the sweep sequencer, its host, the SPI DAC/ADC engines
// and the result consumer. Signal suffixes are from the sequencer's point of view.
interface dac_adc_sweep_ctrl_if #(
  parameter int VW = 12,
  parameter int NW = 7,
  parameter int SW = 29
);
  logic          start_i;
  logic          abort_i;
  logic [VW-1:0] code_start_i;
  logic [VW-1:0] code_step_i;
  logic [NW-1:0] nsteps_i;
  logic [SW-1:0] settle_i;
  logic          stdac_o;
  logic [VW-1:0] dac_code_o;
  logic          eodac_i;
  logic          stadc_o;
  logic          eoadc_i;
  logic [VW-1:0] adc_data_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [VW-1:0] res_code_o;
  logic [VW-1:0] res_data_o;
  logic          busy_o;
  logic          done_o;

  modport master (
    input  start_i, abort_i, code_start_i, code_step_i, nsteps_i, settle_i,
    input  eodac_i, eoadc_i, adc_data_i, res_ready_i,
    output stdac_o, dac_code_o, stadc_o, res_valid_o, res_code_o, res_data_o,
    output busy_o, done_o
  );

  modport slave (
    output start_i, abort_i, code_start_i, code_step_i, nsteps_i, settle_i,
    output eodac_i, eoadc_i, adc_data_i, res_ready_i,
    input  stdac_o, dac_code_o, stadc_o, res_valid_o, res_code_o, res_data_o,
    input  busy_o, done_o
  );
endinterface

// File: rtl/dac_adc_sweep_ctrl.sv
// Bolometer DAC/ADC sweep sequencer: steps the DAC code over N points, settles, averages
// 2**AVG_LOG2 ADC conversions per point and streams one (code, data) result per point.
module dac_adc_sweep_ctrl #(
  parameter int VW       = 12,
  parameter int NW       = 7,
  parameter int SW       = 29,
  parameter int AVG_LOG2 = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  dac_adc_sweep_ctrl_if.master bus
);
  localparam int          AW      = VW + AVG_LOG2;
  localparam int unsigned NSAMP   = 2 ** AVG_LOG2;
  localparam int          CW      = AVG_LOG2 + 1;
  localparam logic [CW-1:0] NSAMP_L = CW'(NSAMP);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_DAC_ST, S_DAC_WAIT, S_SETTLE,
    S_ADC_ST, S_ADC_WAIT, S_OUT, S_NEXT, S_FIN
  } state_e;

  state_e        state_q, state_d;
  logic [VW-1:0] cfg_start_q, cfg_start_d;
  logic [VW-1:0] cfg_step_q, cfg_step_d;
  logic [NW-1:0] cfg_n_q, cfg_n_d;
  logic [SW-1:0] cfg_settle_q, cfg_settle_d;
  logic [VW-1:0] code_q, code_d;
  logic [NW-1:0] pts_q, pts_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          stdac_q, stdac_d;
  logic          stadc_q, stadc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          res_valid_q, res_valid_d;
  logic [VW-1:0] res_code_q, res_code_d;
  logic [VW-1:0] res_data_q, res_data_d;

  logic [VW:0]   code_sum_s;
  logic [VW-1:0] code_sat_s;
  logic [NW-1:0] pts_inc_s;
  logic [CW-1:0] cnt_inc_s;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d      = state_q;
    cfg_start_d  = cfg_start_q;
    cfg_step_d   = cfg_step_q;
    cfg_n_d      = cfg_n_q;
    cfg_settle_d = cfg_settle_q;
    code_d       = code_q;
    pts_d        = pts_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    settle_d     = settle_q;
    code_sum_s   = {1'b0, code_q} + {1'b0, cfg_step_q};
    code_sat_s   = code_sum_s[VW] ? {VW{1'b1}} : code_sum_s[VW-1:0];
    pts_inc_s    = pts_q + 1'b1;
    cnt_inc_s    = cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          cfg_start_d  = bus.code_start_i;
          cfg_step_d   = bus.code_step_i;
          cfg_n_d      = bus.nsteps_i;
          cfg_settle_d = bus.settle_i;
          state_d      = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        code_d = cfg_start_q;
        pts_d  = '0;
        acc_d  = '0;
        cnt_d  = '0;
        if (bus.abort_i || (cfg_n_q == '0)) begin
          state_d = S_FIN;
        end else begin
          state_d = S_DAC_ST;
        end
      end
      S_DAC_ST: state_d = bus.abort_i ? S_FIN : S_DAC_WAIT;
      // An abort here must still let the DAC write complete before leaving
      S_DAC_WAIT: begin
        if (bus.eodac_i) begin
          settle_d = cfg_settle_q;
          state_d  = bus.abort_i ? S_FIN : S_SETTLE;
        end else begin
          state_d = S_DAC_WAIT;
        end
      end
      S_SETTLE: begin
        if (bus.abort_i) begin
          state_d = S_FIN;
        end else if (settle_q == '0) begin
          state_d = S_ADC_ST;
        end else begin
          settle_d = settle_q - 1'b1;
          state_d  = S_SETTLE;
        end
      end
      S_ADC_ST: state_d = bus.abort_i ? S_FIN : S_ADC_WAIT;
      S_ADC_WAIT: begin
        if (bus.eoadc_i) begin
          acc_d = acc_q + AW'(bus.adc_data_i);
          cnt_d = cnt_inc_s;
          if (bus.abort_i) begin
            state_d = S_FIN;
          end else if (cnt_inc_s == NSAMP_L) begin
            state_d = S_OUT;
          end else begin
            state_d = S_ADC_ST;
          end
        end else begin
          state_d = S_ADC_WAIT;
        end
      end
      S_OUT: begin
        if (bus.abort_i) begin
          state_d = S_FIN;
        end else if (bus.res_ready_i) begin
          state_d = S_NEXT;
        end else begin
          state_d = S_OUT;
        end
      end
      S_NEXT: begin
        if (bus.abort_i) begin
          state_d = S_FIN;
        end else begin
          pts_d = pts_inc_s;
          acc_d = '0;
          cnt_d = '0;
          if (pts_inc_s == cfg_n_q) begin
            state_d = S_FIN;
          end else begin
            code_d  = code_sat_s;
            state_d = S_DAC_ST;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet state-aligned
    stdac_d     = (state_d == S_DAC_ST);
    stadc_d     = (state_d == S_ADC_ST);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_q == S_FIN);
    res_valid_d = (state_d == S_OUT);
    if ((state_d == S_OUT) && (state_q != S_OUT)) begin
      res_code_d = code_q;
      res_data_d = acc_d[AW-1 -: VW];
    end else begin
      res_code_d = res_code_q;
      res_data_d = res_data_q;
    end
  end

  // State, configuration, datapath and output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      cfg_start_q  <= '0;
      cfg_step_q   <= '0;
      cfg_n_q      <= '0;
      cfg_settle_q <= '0;
      code_q       <= '0;
      pts_q        <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      settle_q     <= '0;
      stdac_q      <= 1'b0;
      stadc_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      res_code_q   <= '0;
      res_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cfg_start_q  <= cfg_start_d;
      cfg_step_q   <= cfg_step_d;
      cfg_n_q      <= cfg_n_d;
      cfg_settle_q <= cfg_settle_d;
      code_q       <= code_d;
      pts_q        <= pts_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      settle_q     <= settle_d;
      stdac_q      <= stdac_d;
      stadc_q      <= stadc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      res_valid_q  <= res_valid_d;
      res_code_q   <= res_code_d;
      res_data_q   <= res_data_d;
    end
  end

  assign bus.stdac_o     = stdac_q;
  assign bus.dac_code_o  = code_q;
  assign bus.stadc_o     = stadc_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.res_code_o  = res_code_q;
  assign bus.res_data_o  = res_data_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
endmodule

// File: tb/tb_dac_adc_sweep_ctrl.sv
// Self-checking bench: randomised DAC/ADC responders and consumer, with a point-list model
// (code = min(start + k*step, full scale), data = mean of that point's samples).
`timescale 1ns/1ps
module tb_dac_adc_sweep_ctrl;
  localparam int VW = 12, NW = 7, SW = 29, AVG_LOG2 = 2, NS = 4, FS = 4095;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dac_adc_sweep_ctrl_if #(.VW(VW), .NW(NW), .SW(SW)) bus();

  dac_adc_sweep_ctrl #(.VW(VW), .NW(NW), .SW(SW), .AVG_LOG2(AVG_LOG2)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int n_pass = 0, n_total = 0;
  int samples[$];
  int got_code[$], got_data[$];
  int exp_codes[$];
  int dac_total = 0, adc_total = 0, res_total = 0, done_total = 0, eoadc_total = 0;
  int dac_base = 0, adc_base = 0, res_base = 0, samp_base = 0;
  bit ready_hold = 1'b0, ready_rand = 1'b0;
  int adc_mode = 0;
  int adc_dly_fix = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  // DAC writer model: end-of-write pulse 1..4 cycles after stdac_o
  initial begin
    int cnt;
    cnt = -1;
    bus.eodac_i = 1'b0;
    forever begin
      step();
      bus.eodac_i = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.eodac_i = 1'b1;
          cnt = -1;
        end
      end else if (bus.stdac_o) begin
        cnt = $urandom_range(1, 4);
      end
    end
  end

  // ADC reader model: every sample value is logged for the reference model
  initial begin
    int cnt, val;
    cnt = -1;
    val = 0;
    bus.eoadc_i = 1'b0;
    bus.adc_data_i = '0;
    forever begin
      step();
      bus.eoadc_i = 1'b0;
      bus.adc_data_i = VW'($urandom_range(0, FS));
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.eoadc_i = 1'b1;
          bus.adc_data_i = VW'(val);
          cnt = -1;
        end
      end else if (bus.stadc_o) begin
        val = (adc_mode == 1) ? 8 + ((samples.size() - samp_base) % NS) : $urandom_range(0, FS);
        samples.push_back(val);
        cnt = (adc_dly_fix > 0) ? adc_dly_fix : $urandom_range(1, 4);
      end
    end
  end

  initial begin
    bus.res_ready_i = 1'b0;
    forever begin
      step();
      bus.res_ready_i = ready_hold ? 1'b0 : (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Compare process: checks outputs against the model every cycle
  initial begin
    bit pv, px;
    int pc, pd, idx, r, s;
    pv = 1'b0; px = 1'b0; pc = 0; pd = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        px = 1'b0;
      end else begin
        if (bus.done_o) done_total++;
        if (bus.eoadc_i) eoadc_total++;
        if (bus.stadc_o) adc_total++;
        if (bus.stdac_o) begin
          idx = dac_total - dac_base;
          if (idx < exp_codes.size()) check("dac_code", int'(bus.dac_code_o), exp_codes[idx]);
          else check("stdac_count", idx + 1, exp_codes.size());
          check("stdac_while_valid", int'(bus.res_valid_o), 0);
          dac_total++;
        end
        if (bus.res_valid_o && pv && !px) begin
          check("res_code_stable", int'(bus.res_code_o), pc);
          check("res_data_stable", int'(bus.res_data_o), pd);
        end
        if (bus.res_valid_o && bus.res_ready_i) begin
          r = res_total - res_base;
          if (r < exp_codes.size() && samp_base + NS * r + NS <= samples.size()) begin
            s = 0;
            for (int j = 0; j < NS; j++) s += samples[samp_base + NS * r + j];
            check("res_code", int'(bus.res_code_o), exp_codes[r]);
            check("res_data", int'(bus.res_data_o), s / NS);
          end else begin
            check("res_count", r + 1, exp_codes.size());
          end
          got_code.push_back(int'(bus.res_code_o));
          got_data.push_back(int'(bus.res_data_o));
          res_total++;
        end
        pv = bus.res_valid_o;
        px = bus.res_valid_o && bus.res_ready_i;
        pc = int'(bus.res_code_o);
        pd = int'(bus.res_data_o);
      end
    end
  end

  task automatic start_sweep(input int cs, input int stp, input int n, input int st);
    exp_codes.delete();
    for (int k = 0; k < n; k++) exp_codes.push_back((cs + k * stp > FS) ? FS : cs + k * stp);
    dac_base = dac_total; adc_base = adc_total; res_base = res_total; samp_base = samples.size();
    bus.code_start_i = VW'(cs);
    bus.code_step_i  = VW'(stp);
    bus.nsteps_i     = NW'(n);
    bus.settle_i     = SW'(st);
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    bus.code_start_i = VW'($urandom_range(0, FS));
    bus.code_step_i  = VW'($urandom_range(0, FS));
    bus.nsteps_i     = NW'($urandom_range(0, 127));
    bus.settle_i     = SW'($urandom_range(0, 1000));
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0, k;
    d0 = done_total;
    k = 0;
    while (done_total == d0 && k < budget) begin
      step();
      k++;
    end
    check({tag, "_done"}, done_total - d0, 1);
  endtask

  task automatic finish_sweep(input int n, input string tag);
    wait_done(3000, tag);
    check({tag, "_results"}, res_total - res_base, n);
    check({tag, "_stdac_n"}, dac_total - dac_base, n);
    check({tag, "_stadc_n"}, adc_total - adc_base, NS * n);
    check({tag, "_busy_idle"}, int'(bus.busy_o), 0);
    step();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stdac"}, int'(bus.stdac_o), 0);
    check({tag, "_stadc"}, int'(bus.stadc_o), 0);
    check({tag, "_dac_code"}, int'(bus.dac_code_o), 0);
    check({tag, "_res_valid"}, int'(bus.res_valid_o), 0);
    check({tag, "_res_code"}, int'(bus.res_code_o), 0);
    check({tag, "_res_data"}, int'(bus.res_data_o), 0);
    check({tag, "_busy"}, int'(bus.busy_o), 0);
    check({tag, "_done"}, int'(bus.done_o), 0);
  endtask

  initial begin
    int k, d0, c0, e0, lit_code[3];
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    bus.code_start_i = '0; bus.code_step_i = '0; bus.nsteps_i = '0; bus.settle_i = '0;
    repeat (3) step();
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) step();

    // 1: table ADC 8,9,10,11 -> every point averages to 9
    adc_mode = 1;
    start_sweep(100, 50, 3, 5);
    finish_sweep(3, "t1");
    lit_code[0] = 100; lit_code[1] = 150; lit_code[2] = 200;
    for (int i = 0; i < 3; i++) begin
      if (res_base + i < got_code.size()) begin
        check("t1_lit_code", got_code[res_base + i], lit_code[i]);
        check("t1_lit_data", got_data[res_base + i], 9);
      end else begin
        check("t1_lit_missing", got_code.size(), res_base + i + 1);
      end
    end
    adc_mode = 0;

    // 2: back-pressure on the first result
    ready_hold = 1'b1;
    start_sweep(300, 1, 2, 3);
    k = 0;
    while (!bus.res_valid_o && k < 500) begin step(); k++; end
    check("t2_valid_seen", int'(bus.res_valid_o), 1);
    d0 = dac_total;
    c0 = int'(bus.res_code_o);
    repeat (20) step();
    check("t2_valid_held", int'(bus.res_valid_o), 1);
    check("t2_no_stdac", dac_total - d0, 0);
    check("t2_code_held", int'(bus.res_code_o), c0);
    ready_hold = 1'b0;
    finish_sweep(2, "t2");

    // 3: saturation at full scale
    start_sweep(4000, 100, 3, 1);
    finish_sweep(3, "t3");
    lit_code[0] = 4000; lit_code[1] = 4095; lit_code[2] = 4095;
    for (int i = 0; i < 3; i++) begin
      if (res_base + i < got_code.size()) check("t3_lit_code", got_code[res_base + i], lit_code[i]);
      else check("t3_lit_missing", got_code.size(), res_base + i + 1);
    end

    // 4: zero points -> LOAD, FIN, IDLE with done
    d0 = done_total;
    start_sweep(10, 10, 0, 3);
    check("t4_busy_c1", int'(bus.busy_o), 1);
    check("t4_done_c1", int'(bus.done_o), 0);
    step();
    check("t4_busy_c2", int'(bus.busy_o), 1);
    check("t4_done_c2", int'(bus.done_o), 0);
    step();
    check("t4_busy_c3", int'(bus.busy_o), 0);
    check("t4_done_c3", int'(bus.done_o), 1);
    step();
    check("t4_done_once", done_total - d0, 1);
    check("t4_no_stdac", dac_total - dac_base, 0);
    check("t4_no_stadc", adc_total - adc_base, 0);

    // 5: abort during ADC_WAIT waits for the conversion, then a clean restart
    adc_dly_fix = 6;
    e0 = eoadc_total;
    start_sweep(1000, 10, 3, 2);
    k = 0;
    while (adc_total == adc_base && k < 200) begin step(); k++; end
    bus.abort_i = 1'b1;
    wait_done(200, "t5");
    check("t5_eoadc_before_done", eoadc_total - e0, 1);
    check("t5_no_result", res_total - res_base, 0);
    bus.abort_i = 1'b0;
    adc_dly_fix = 0;
    step();
    start_sweep(2000, 300, 2, 0);
    finish_sweep(2, "t5b");

    // Randomised sweeps with random back-pressure
    ready_rand = 1'b1;
    for (int i = 0; i < 8; i++) begin
      start_sweep($urandom_range(0, FS), $urandom_range(0, 1500), $urandom_range(1, 6), $urandom_range(0, 6));
      finish_sweep(exp_codes.size(), "rnd");
    end
    ready_rand = 1'b0;

    // 6: start while busy is ignored; reset in SETTLE clears everything without done
    d0 = done_total;
    start_sweep(500, 7, 2, 30);
    k = 0;
    while (dac_total == dac_base && k < 100) begin step(); k++; end
    bus.nsteps_i = '0;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    repeat (6) step();
    check("t6_busy_settle", int'(bus.busy_o), 1);
    check("t6_start_ignored", done_total - d0, 0);
    rst_n = 1'b0;
    #1;
    check_zero("t6_rst");
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();
    check("t6_no_done", done_total - d0, 0);
    start_sweep(50, 5, 1, 0);
    finish_sweep(1, "t6b");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
